// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory arbiter
package dmem_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    function automatic logic [2:0] access_bytes(input logic [1:0] size_code);
        case (size_code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Last-byte check is done in 33 bits so addresses near 2^32 cannot wrap into range.
    function automatic logic access_fault(input logic        wen,
                                          input logic [31:0] addr,
                                          input logic [2:0]  funct3,
                                          input logic [32:0] mem_bytes);
        logic [32:0] last_byte;
        logic        bad_code;
        logic        bad_align;
        last_byte = {1'b0, addr} + {30'b0, access_bytes(funct3[1:0])} - 33'd1;
        bad_code  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        bad_align = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        return bad_code || (wen && funct3[2]) || bad_align || (last_byte >= mem_bytes);
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// rtl/dmem_rr_arb.sv - two-way round-robin grant, one-hot output
module dmem_rr_arb
    import dmem_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        grant = '0;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter, one transaction outstanding
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [5:0]  req_funct3,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_wen,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_byte_mask,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] MEM_BYTES = 33'(WORDS * 4);

    state_e             state;
    state_e             state_nxt;
    logic [NUM_REQ-1:0] grant;
    logic               last_grant;
    logic               owner;
    logic               acc_wen;
    logic               acc_fault;
    logic               accept;
    logic               sel;
    logic               sel_wen;
    logic               sel_fault;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [2:0]         sel_funct3;

    dmem_rr_arb u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sel        = grant[1];
    assign sel_wen    = req_wen[sel];
    assign sel_addr   = sel ? req_addr[63:32]   : req_addr[31:0];
    assign sel_wdata  = sel ? req_wdata[63:32]  : req_wdata[31:0];
    assign sel_funct3 = sel ? req_funct3[5:3]   : req_funct3[2:0];
    assign sel_fault  = access_fault(sel_wen, sel_addr, sel_funct3, MEM_BYTES);
    assign accept     = (state == S_IDLE) && (|req_valid);

    // A faulting store never reaches the memory write strobe.
    assign mem_wen = (state == S_ACCESS) && acc_wen && !acc_fault;

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            S_IDLE: begin
                req_ready = grant;
                if (|req_valid) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            acc_wen       <= 1'b0;
            acc_fault     <= 1'b0;
            mem_address   <= '0;
            mem_wdata     <= '0;
            mem_byte_mask <= F3_W;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner         <= sel;
                last_grant    <= sel;
                acc_wen       <= sel_wen;
                acc_fault     <= sel_fault;
                mem_address   <= sel_addr;
                mem_wdata     <= sel_wdata;
                mem_byte_mask <= sel_funct3;
            end
            if (state == S_ACCESS) begin
                rsp_rdata <= (acc_wen || acc_fault) ? 32'h0 : mem_rdata;
                rsp_err   <= acc_fault;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WORDS, default 128, meaning data memory depth in 32-bit words (byte range 0..WORDS*4-1).
REQ-002 SHALL have port clk  input  1  single clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  2  request present, bit i = requester i (0 = core LSU, 1 = DMA/debug).
REQ-005 SHALL have port req_ready  output  2  request accepted this cycle when valid&ready.
REQ-006 SHALL have port req_wen  input  2  per-requester store flag.
REQ-007 SHALL have port req_addr  input  2x32  per-requester byte address.
REQ-008 SHALL have port req_wdata  input  2x32  per-requester store data, LSB-aligned.
REQ-009 SHALL have port req_funct3  input  2x3  per-requester size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-010 SHALL have port rsp_valid  output  2  response available to requester i.
REQ-011 SHALL have port rsp_ready  input  2  requester i consumes response.
REQ-012 SHALL have port rsp_rdata  output  32  load data, shared bus, meaningful only with rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  access fault, qualified by rsp_valid.
REQ-014 SHALL have ports mem_wen (output, 1), mem_address (output, 32), mem_wdata (output, 32), mem_byte_mask (output, 3), mem_rdata (input, 32), driving the data memory (sync write, async read).

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; one transaction outstanding at a time.
REQ-016 In IDLE: req_ready[i] SHALL be 1 only for the granted requester i, and only when req_valid[i]=1; otherwise 0.
REQ-017 Grant SHALL be round-robin: a single requester wins; if both are valid, the one not granted last wins; last_grant updates on each acceptance.
REQ-018 On acceptance (cycle N), the request fields and owner index SHALL be registered and the FSM SHALL go to ACCESS (N+1).
REQ-019 Fault SHALL be flagged at acceptance for: funct3 in {011,110,111}; store with funct3[2]=1; H/HU with addr[0]=1; W with addr[1:0]!=0; addr+size-1 >= WORDS*4.
REQ-020 In ACCESS, the block SHALL drive mem_address/mem_wdata/mem_byte_mask from the registered request, with mem_wen=1 only for a non-faulting store.
REQ-021 In ACCESS, it SHALL capture mem_rdata into rsp_rdata at the clock edge (0 for stores and faults), then go to RESP.
REQ-022 In RESP, rsp_valid[owner] SHALL be 1 (other bit 0), with rsp_rdata/rsp_err held stable until rsp_ready[owner]=1; then go to IDLE.
REQ-023 Latency SHALL be: accept at N, memory cycle N+1, rsp_valid from N+2; back-to-back throughput is one transaction per 3 cycles.
REQ-024 A faulting request SHALL perform no memory write and SHALL return rsp_err=1.
REQ-025 mem_wen SHALL be 0 in every state except ACCESS; the other mem_* outputs hold their last registered values.
REQ-026 req_valid changes while a requester is not granted SHALL have no effect; a pending request SHALL be served no later than the transaction after the current one.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wen=0, mem_address=0, mem_wdata=0, mem_byte_mask=3'b010, last_grant=1 (requester 0 wins first).
REQ-028 Reset asserted in ACCESS or RESP SHALL abort the transaction: no write issued after the reset edge, no response delivered.

Structure
REQ-029 Package dmem_pkg SHALL hold the funct3 enum (B/H/W/BU/HU), the FSM state enum, and the requester-count constant (2).
REQ-030 The round-robin grant SHALL be a sub-module, dmem_rr_arb (inputs valid[1:0], last_grant; output one-hot grant).

Verification
REQ-031 Scenario: r0 SW addr 0x10 data 0xCAFEF00D, then r0 LW 0x10 -> second response rdata 0xCAFEF00D, err 0, rsp_valid at accept+2.
REQ-032 Scenario: both valid at once after reset -> r0 granted first, r1 next; with both held continuously, grants alternate 0,1,0,1.
REQ-033 Scenario: r1 LH addr 0x11 and LW addr 0x1FE (WORDS=128) -> rsp_err=1, mem_wen never 1, memory unchanged.
REQ-034 Scenario: byte 0x80 stored at 0x20; LB -> 0xFFFFFF80, LBU -> 0x00000080.
REQ-035 Scenario: rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-036 Scenario: rst_n pulsed low during ACCESS of a store -> target word unchanged, all outputs at reset values.
